// File: rtl/rssb_seq.sv
// Run controller for the 1-bit RSSB core: gates core execution, owns the host
// data-memory write port, and runs free or single-steps until halt or watchdog.
module rssb_seq #(
  parameter int IW      = 4,
  parameter int DW      = 4,
  parameter int BW      = 1,
  parameter int HALT_PC = 12,
  parameter int CW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [DW-1:0] cmd_addr,
  input  logic [BW-1:0] cmd_data,
  input  logic [IW-1:0] core_pc,
  output logic          core_ena,
  output logic          dm_we,
  output logic [DW-1:0] dm_addr,
  output logic [BW-1:0] dm_wdata,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cyc_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP} state_e;

  localparam logic [1:0]    OP_LOAD  = 2'b00;
  localparam logic [1:0]    OP_RUN   = 2'b01;
  localparam logic [1:0]    OP_STEP  = 2'b10;
  localparam logic [1:0]    OP_ABORT = 2'b11;
  localparam logic [CW-1:0] CYC_MAX  = '1;
  localparam logic [IW-1:0] HALT     = IW'(HALT_PC);

  state_e        state_q, state_d;
  logic          core_ena_q, core_ena_d;
  logic          dm_we_q, dm_we_d;
  logic [DW-1:0] dm_addr_q, dm_addr_d;
  logic [BW-1:0] dm_wdata_q, dm_wdata_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          timeout_q, timeout_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [CW-1:0] cyc_inc;
  logic          accept, at_halt;

  assign cmd_ready = (state_q == S_IDLE) | (cmd_op == OP_ABORT);
  assign accept    = cmd_valid & cmd_ready;
  assign cyc_inc   = (cyc_q == CYC_MAX) ? cyc_q : cyc_q + 1'b1;
  assign at_halt   = (core_pc == HALT);

  always_comb begin
    state_d    = state_q;
    core_ena_d = core_ena_q;
    dm_we_d    = 1'b0;
    dm_addr_d  = dm_addr_q;
    dm_wdata_d = dm_wdata_q;
    done_d     = done_q;
    timeout_d  = timeout_q;
    cyc_d      = cyc_q;
    unique case (state_q)
      S_IDLE: begin
        core_ena_d = 1'b0;
        if (accept) begin
          unique case (cmd_op)
            OP_LOAD: begin
              dm_we_d    = 1'b1;
              dm_addr_d  = cmd_addr;
              dm_wdata_d = cmd_data;
            end
            OP_RUN: begin
              state_d    = S_RUN;
              core_ena_d = 1'b1;
              cyc_d      = '0;
              done_d     = 1'b0;
              timeout_d  = 1'b0;
            end
            OP_STEP: begin
              state_d    = S_STEP;
              core_ena_d = 1'b1;
              done_d     = 1'b0;
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (core_ena_q) begin
          cyc_d = cyc_inc;
          // Halt has priority over the watchdog when both land on one edge.
          if (at_halt) begin
            state_d    = S_IDLE;
            core_ena_d = 1'b0;
            done_d     = 1'b1;
          end else if (cyc_inc == CYC_MAX) begin
            state_d    = S_IDLE;
            core_ena_d = 1'b0;
            done_d     = 1'b1;
            timeout_d  = 1'b1;
          end
        end
        if (accept && cmd_op == OP_ABORT) begin
          state_d    = S_IDLE;
          core_ena_d = 1'b0;
        end
      end
      S_STEP: begin
        if (core_ena_q) begin
          cyc_d = cyc_inc;
          if (at_halt) done_d = 1'b1;
        end
        state_d    = S_IDLE;
        core_ena_d = 1'b0;
      end
      default: begin
        state_d    = S_IDLE;
        core_ena_d = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      core_ena_q <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      cyc_q      <= '0;
    end else begin
      state_q    <= state_d;
      core_ena_q <= core_ena_d;
      dm_we_q    <= dm_we_d;
      dm_addr_q  <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      cyc_q      <= cyc_d;
    end
  end

  assign core_ena = core_ena_q;
  assign dm_we    = dm_we_q;
  assign dm_addr  = dm_addr_q;
  assign dm_wdata = dm_wdata_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign timeout  = timeout_q;
  assign cyc_cnt  = cyc_q;

endmodule

// File: tb/tb_rssb_seq.sv
// Directed bench for rssb_seq with a small core-PC model and a write scoreboard.
module tb_rssb_seq;
  localparam int IW = 4, DW = 4, BW = 1, CW = 4;
  localparam logic [1:0] LOAD = 2'b00, RUN = 2'b01, STEP = 2'b10, ABORT = 2'b11;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [DW-1:0] cmd_addr = '0;
  logic [BW-1:0] cmd_data = '0;
  logic [IW-1:0] core_pc;
  logic          core_ena, dm_we, busy, done, timeout;
  logic [DW-1:0] dm_addr;
  logic [BW-1:0] dm_wdata;
  logic [CW-1:0] cyc_cnt;

  int tests = 0;
  int fails = 0;

  // Core model: PC either holds or advances once per enabled cycle.
  int            ena_total = 0;
  int            ena_base = 0;
  logic [IW-1:0] pc_start = '0;
  logic          pc_inc = 1'b0;
  logic [DW+BW-1:0] wr_q[$];

  assign core_pc = pc_inc ? IW'(int'(pc_start) + ena_total - ena_base) : pc_start;

  rssb_seq #(.IW(IW), .DW(DW), .BW(BW), .HALT_PC(12), .CW(CW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .core_pc(core_pc), .core_ena(core_ena), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .busy(busy), .done(done), .timeout(timeout),
    .cyc_cnt(cyc_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (core_ena) ena_total <= ena_total + 1;

  // Scoreboard: every host write strobe must match the oldest accepted LOAD.
  always @(negedge clk) begin
    if (rst && dm_we) begin
      tests++;
      if (wr_q.size() == 0) begin
        fails++;
        $error("FAIL wr_unexpected: observed write %0h:%0h expected none", dm_addr, dm_wdata);
      end else begin
        logic [DW+BW-1:0] exp_w;
        exp_w = wr_q.pop_front();
        assert ({dm_addr, dm_wdata} === exp_w)
          else begin fails++; $error("FAIL wr_data: observed %0h expected %0h", {dm_addr, dm_wdata}, exp_w); end
      end
    end
    if (rst && dm_we && core_ena) begin
      fails++;
      $error("FAIL excl: observed dm_we=1 core_ena=1 expected not both");
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v)
      else begin fails++; $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v); end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present a command, wait (bounded) for ready, return 1ns after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [DW-1:0] a, input logic [BW-1:0] d);
    int n;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
    #1;
    n = 0;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    if (!cmd_ready) begin
      tests++; fails++;
      $error("FAIL issue_timeout: observed ready=0 expected ready=1 for op %0d", op);
    end else begin
      if (op == LOAD) wr_q.push_back({a, d});
      tick();
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int lim);
    int n;
    n = 0;
    while (busy && n < lim) begin tick(); n++; end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    // Reset overrides a valid RUN command.
    rst = 1'b0; cmd_valid = 1'b1; cmd_op = RUN;
    tick();
    tick();
    chk("rst_outs", {core_ena, dm_we, busy, done, timeout}, 32'd0);
    chk("rst_dm", {dm_addr, dm_wdata}, 32'd0);
    chk("rst_cyc", cyc_cnt, 32'd0);
    chk("rst_ready", cmd_ready, 32'd1);
    cmd_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("rst_nostart", busy, 32'd0);

    // Back-to-back LOADs.
    issue(LOAD, 4'd0, 1'b1);
    chk("ld0_we", {dm_we, dm_addr, dm_wdata}, {27'd0, 1'b1, 4'd0, 1'b1});
    issue(LOAD, 4'd1, 1'b0);
    chk("ld1_we", {dm_we, dm_addr, dm_wdata}, {27'd0, 1'b1, 4'd1, 1'b0});
    chk("ld_ena", core_ena, 32'd0);
    tick();
    chk("ld_we_off", dm_we, 32'd0);

    // Run to halt from PC 15: executes 15,0,...,12 = 14 steps.
    pc_start = 4'd15; pc_inc = 1'b1; ena_base = ena_total;
    issue(RUN, 4'd9, 1'b1);
    chk("run_start", {busy, core_ena, done, timeout}, 32'b1100);
    chk("run_cyc0", cyc_cnt, 32'd0);
    wait_idle("run_halt_idle", 40);
    chk("run_halt_ena", core_ena, 32'd0);
    chk("run_halt_cyc", cyc_cnt, 32'd14);
    chk("run_halt_steps", ena_total - ena_base, 32'd14);
    chk("run_halt_flags", {done, timeout}, 32'b10);
    chk("run_halt_ready", cmd_ready, 32'd1);

    // Watchdog at 2^CW-1 with PC stuck.
    pc_start = 4'd3; pc_inc = 1'b0; ena_base = ena_total;
    issue(RUN, 4'd0, 1'b0);
    wait_idle("wd_idle", 40);
    chk("wd_steps", ena_total - ena_base, 32'd15);
    chk("wd_cyc", cyc_cnt, 32'd15);
    chk("wd_flags", {done, timeout}, 32'b11);

    // STEP after watchdog: counter saturates, timeout untouched.
    issue(STEP, 4'd0, 1'b0);
    tick();
    chk("sat_cyc", cyc_cnt, 32'd15);
    chk("sat_flags", {done, timeout}, 32'b01);

    // Clear via reset, then three single steps with a stalled LOAD.
    rst = 1'b0; tick(); rst = 1'b1;
    pc_start = 4'd5; pc_inc = 1'b1; ena_base = ena_total;
    issue(STEP, 4'd0, 1'b0);
    chk("st1_ena", core_ena, 32'd1);
    cmd_valid = 1'b1; cmd_op = LOAD; cmd_addr = 4'd5; cmd_data = 1'b1;
    #1;
    chk("st_stall", cmd_ready, 32'd0);
    issue(LOAD, 4'd5, 1'b1);
    chk("st_ld_we", {dm_we, dm_addr, core_ena}, {26'd0, 1'b1, 4'd5, 1'b0});
    issue(STEP, 4'd0, 1'b0);
    chk("st2_ena", core_ena, 32'd1);
    tick();
    chk("st2_off", core_ena, 32'd0);
    issue(STEP, 4'd0, 1'b0);
    tick();
    chk("st_cyc", cyc_cnt, 32'd3);
    chk("st_pulses", ena_total - ena_base, 32'd3);
    chk("st_flags", {done, timeout, busy}, 32'd0);

    // STEP on the halt PC sets done.
    pc_start = 4'd12; pc_inc = 1'b0;
    issue(STEP, 4'd0, 1'b0);
    tick();
    chk("st_halt", {done, timeout}, 32'b10);
    chk("st_halt_cyc", cyc_cnt, 32'd4);

    // ABORT after 5 enabled cycles; the abort-edge step still counts.
    pc_start = 4'd0; pc_inc = 1'b1; ena_base = ena_total;
    issue(RUN, 4'd0, 1'b0);
    repeat (5) tick();
    chk("ab_pre", ena_total - ena_base, 32'd5);
    cmd_valid = 1'b1; cmd_op = ABORT;
    #1;
    chk("ab_ready", cmd_ready, 32'd1);
    tick();
    cmd_valid = 1'b0;
    chk("ab_ena", {core_ena, busy}, 32'd0);
    chk("ab_cyc", cyc_cnt, 32'd6);
    chk("ab_done", {done, timeout}, 32'd0);
    tick();
    chk("ab_steps", ena_total - ena_base, 32'd6);

    // Restart: counter cleared, PC continues 6..12 = 7 steps.
    issue(RUN, 4'd0, 1'b0);
    chk("rr_cyc0", {busy, cyc_cnt}, {27'd0, 1'b1, 4'd0});
    wait_idle("rr_idle", 40);
    chk("rr_cyc", cyc_cnt, 32'd7);
    chk("rr_done", {done, timeout}, 32'b10);

    // ABORT in IDLE does nothing.
    issue(ABORT, 4'd0, 1'b0);
    chk("ab_idle", {busy, core_ena, done, cyc_cnt}, {27'd0, 1'b0, 1'b0, 1'b1, 4'd7});

    tick();
    chk("wrq_empty", wr_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rssb_seq.md
# rssb_seq

Run controller for the 1-bit RSSB core. Sits between a host command port and the core's memory/PC block:
- gates the core's execute enable;
- owns the data-memory host write port, which it drives only while the core is stopped;
- runs free or single-steps the program;
- stops on a halt PC or a watchdog limit, and reports a cycle count.

## Interface
- IW, 4, core PC width
- DW, 4, data-memory index width
- BW, 1, data width
- HALT_PC, 12, PC value that terminates a run (start of the 111 halt pattern)
- CW, 8, cycle-counter width; watchdog limit is 2^CW-1
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  command accepted when valid & ready at posedge clk
- cmd_op  in  2  00 LOAD, 01 RUN, 10 STEP, 11 ABORT
- cmd_addr  in  DW  LOAD target index
- cmd_data  in  BW  LOAD data
- core_pc  in  IW  current core PC
- core_ena  out  1  core execute enable (registered)
- dm_we  out  1  host data-memory write strobe to core (registered)
- dm_addr  out  DW  host write index (registered)
- dm_wdata  out  BW  host write data (registered)
- busy  out  1  high in RUN or STEP
- done  out  1  sticky: last run/step ended on HALT_PC or watchdog
- timeout  out  1  sticky: last run ended on watchdog
- cyc_cnt  out  CW  enabled core cycles since last RUN, saturating

## Operation
- States: IDLE, RUN, STEP.
- Reset (rst=0 at posedge clk) forces:
  - state IDLE;
  - core_ena=0, dm_we=0, dm_addr=0, dm_wdata=0;
  - busy=0, done=0, timeout=0, cyc_cnt=0.
- Reset overrides any command in the same cycle.
- cmd_ready = (state==IDLE) | (cmd_op==ABORT). Non-ABORT commands stall while busy.
- LOAD in IDLE:
  - next cycle: dm_we=1, dm_addr=cmd_addr, dm_wdata=cmd_data;
  - dm_we is high for exactly one cycle per accepted LOAD;
  - back-to-back LOADs give consecutive one-cycle writes;
  - core_ena stays 0.
- RUN in IDLE:
  - clears cyc_cnt, done and timeout;
  - state becomes RUN and core_ena=1 from the next cycle.
- In RUN, at each posedge with core_ena=1:
  - cyc_cnt increments, saturating at 2^CW-1;
  - if core_pc==HALT_PC: state becomes IDLE, core_ena=0, done=1. The instruction at HALT_PC has executed exactly once.
  - else if the incremented cyc_cnt reaches 2^CW-1: state becomes IDLE, core_ena=0, done=1, timeout=1.
  - If halt and watchdog occur in the same cycle, halt wins: timeout=0.
- STEP in IDLE:
  - clears done; state becomes STEP; core_ena=1 for exactly one cycle; cyc_cnt increments once (not cleared).
  - At the end of that cycle the state returns to IDLE.
  - done=1 if core_pc==HALT_PC during the step. timeout is unaffected.
- ABORT:
  - in RUN or STEP: state becomes IDLE, core_ena=0 next cycle; done and timeout unchanged; cyc_cnt holds.
  - in IDLE: no effect.
- cmd_addr and cmd_data are ignored for RUN, STEP and ABORT.
- Invariant: dm_we and core_ena are never both 1.

## Timing
- All outputs are registered except cmd_ready, which is combinational from state and cmd_op.
- Command accepted at edge N: state, core_ena and dm_we change at edge N; effects are visible in cycle N+1.
- RUN accepted at edge N: the first core step executes at edge N+1.
- Stop decided at edge M (core step M executes): core_ena=0 in cycle M+1; no further core step occurs.
- ABORT accepted at edge N during RUN: the core step at edge N still executes (core_ena was 1); none after.
- LOAD accepted at edge N: the write is committed by the core at edge N+1.
- A new command is accepted in the first IDLE cycle after a stop.

## Test plan
- Reset values:
  - stimulus: hold rst=0 for 2 cycles with cmd_valid=1 and op=RUN;
  - response: all outputs 0, cmd_ready=1, no state change.
- LOAD sequence:
  - stimulus: LOADs (addr 0, data 1) then (addr 1, data 0), back-to-back;
  - response: dm_we high 2 consecutive cycles with matching addr/data; core_ena=0 throughout.
- Run to halt:
  - stimulus: model core_pc incrementing from 15 (wrap to 0) on each enabled cycle; issue RUN;
  - response: stop when core_pc==12; cyc_cnt=14, done=1, timeout=0, busy drops the cycle after.
- Watchdog:
  - stimulus: CW=4, core_pc held at 3, RUN;
  - response: core_ena high exactly 15 cycles; cyc_cnt=15, done=1, timeout=1.
- STEP and stall:
  - stimulus: STEP three times;
  - response: three single-cycle core_ena pulses; cyc_cnt=3; a LOAD presented during a STEP stalls (cmd_ready=0) until IDLE.
- ABORT mid-run:
  - stimulus: RUN, then ABORT after 5 enabled cycles;
  - response: core_ena falls the next cycle; cyc_cnt=6; done=0; a following RUN restarts with cyc_cnt cleared.
